// File: rtl/pio_led_blink.sv
// Avalon-MM output PIO for board LEDs: data register with atomic set/clear, per-bit blink.
// Optional PWM dimming (DUTY register at address 6) is built when PIO_LED_PWM_EN is defined.
module pio_led_blink #(
    parameter int unsigned           WIDTH        = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE  = '0,
    parameter int unsigned           PERIOD_W     = 24,
    parameter logic [PERIOD_W-1:0]   PERIOD_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                wr_en;
    logic [WIDTH-1:0]    wr_field;
    logic [PERIOD_W-1:0] wr_period;
    logic                unused_wdata;

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                gate;

    assign wr_en        = chipselect & ~write_n;
    assign wr_field     = writedata[WIDTH-1:0];
    assign wr_period    = writedata[PERIOD_W-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        if (wr_en) begin
            case (address)
                3'd0:    data_d   = wr_field;
                3'd1:    mask_d   = wr_field;
                3'd2:    period_d = wr_period;
                3'd3:    data_d   = data_q | wr_field;
                3'd4:    data_d   = data_q & ~wr_field;
                default: ;
            endcase
        end

        // A PERIOD write restarts the prescaler so the next toggle lands on the following edge.
        if (wr_en && address == 3'd2) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q - PERIOD_W'(1);
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= PERIOD_RESET;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

`ifdef PIO_LED_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (wr_en && address == 3'd6) begin
            duty_d = writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign gate = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
`else
    assign gate = 1'b1;
`endif

    assign out_port = data_q & (~mask_q | {WIDTH{phase_q}}) & {WIDTH{gate}};

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0]    = data_q;
            3'd1: readdata[WIDTH-1:0]    = mask_q;
            3'd2: readdata[PERIOD_W-1:0] = period_q;
            3'd5: begin
                // Count sits above the phase bit; a 32-bit count loses its MSB on the bus.
                readdata[0] = phase_q;
                for (int unsigned i = 0; i < PERIOD_W && i < 31; i++) begin
                    readdata[i+1] = cnt_q[i];
                end
            end
`ifdef PIO_LED_PWM_EN
            3'd6: readdata[7:0] = duty_q;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pio_led_blink.sv
// Directed bench for pio_led_blink (default build, RESET_VALUE = 8'hA5): register
// vector table followed by hand-written blink, period-change and async reset sequences.
module tb_pio_led_blink;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_vec = 0;
    int n_err = 0;

    pio_led_blink #(
        .WIDTH        (8),
        .RESET_VALUE  (8'hA5),
        .PERIOD_W     (24),
        .PERIOD_RESET (24'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    logic [31:0] blink_st  [9];
    logic [7:0]  blink_out [9];

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'h0,        3'd0, 32'h000000A5, 8'hA5};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,        3'd1, 32'h00000000, 8'hA5};
        vecs[2]  = '{1'b0, 3'd0, 32'h0,        3'd2, 32'h00000000, 8'hA5};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,        3'd5, 32'h00000001, 8'hA5};
        vecs[4]  = '{1'b0, 3'd0, 32'h0,        3'd3, 32'h00000000, 8'hA5};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,        3'd4, 32'h00000000, 8'hA5};
        vecs[6]  = '{1'b0, 3'd0, 32'h0,        3'd6, 32'h00000000, 8'hA5};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,        3'd7, 32'h00000000, 8'hA5};
        vecs[8]  = '{1'b1, 3'd0, 32'h3C,       3'd0, 32'h0000003C, 8'h3C};
        vecs[9]  = '{1'b1, 3'd3, 32'h81,       3'd0, 32'h000000BD, 8'hBD};
        vecs[10] = '{1'b1, 3'd4, 32'h0C,       3'd0, 32'h000000B1, 8'hB1};
        vecs[11] = '{1'b1, 3'd3, 32'h0,        3'd0, 32'h000000B1, 8'hB1};
        vecs[12] = '{1'b1, 3'd4, 32'h0,        3'd0, 32'h000000B1, 8'hB1};
        vecs[13] = '{1'b1, 3'd5, 32'hFFFFFFFF, 3'd5, 32'h00000001, 8'hB1};
        vecs[14] = '{1'b1, 3'd7, 32'hFFFFFFFF, 3'd0, 32'h000000B1, 8'hB1};
        vecs[15] = '{1'b1, 3'd6, 32'hFF,       3'd6, 32'h00000000, 8'hB1};
        vecs[16] = '{1'b1, 3'd7, 32'h12345678, 3'd7, 32'h00000000, 8'hB1};
        vecs[17] = '{1'b1, 3'd4, 32'hFFFFFFFF, 3'd4, 32'h00000000, 8'h00};
        vecs[18] = '{1'b1, 3'd0, 32'hFFFFFF5A, 3'd0, 32'h0000005A, 8'h5A};
        vecs[19] = '{1'b1, 3'd0, 32'hFF,       3'd0, 32'h000000FF, 8'hFF};
        vecs[20] = '{1'b1, 3'd1, 32'h00001F0F, 3'd1, 32'h0000000F, 8'hFF};
        vecs[21] = '{1'b1, 3'd2, 32'hFFFFFFFF, 3'd2, 32'h00FFFFFF, 8'hFF};

        // PERIOD=4 from a fresh restart: status = {cnt, phase}
        blink_st  = '{32'h6, 32'h4, 32'h2, 32'h0, 32'h7, 32'h5, 32'h3, 32'h1, 32'h6};
        blink_out = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) do_write(vecs[i].waddr, vecs[i].wdata);
            check_rd($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
        end

        // Maximum period: reload to FFFFFE with phase 0 on the first edge.
        @(posedge clk);
        #1;
        check_rd("maxper_status", 3'd5, 32'h01FFFFFC);
        check("maxper_out", {24'h0, out_port}, 32'h000000F0);

        do_write(3'd2, 32'h4);
        check_rd("p4_period", 3'd2, 32'h4);
        check_rd("p4_restart_status", 3'd5, 32'h1);
        check("p4_restart_out", {24'h0, out_port}, 32'h000000FF);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check_rd($sformatf("p4_status%0d", k), 3'd5, blink_st[k]);
            check($sformatf("p4_out%0d", k), {24'h0, out_port}, {24'h0, blink_out[k]});
        end

        do_write(3'd2, 32'h0);
        for (int k = 0; k < 10; k++) begin
            check_rd($sformatf("p0_status%0d", k), 3'd5, 32'h1);
            check($sformatf("p0_out%0d", k), {24'h0, out_port}, 32'h000000FF);
            @(posedge clk);
            #1;
        end

        do_write(3'd2, 32'h1);
        check_rd("p1_restart_status", 3'd5, 32'h1);
        check("p1_restart_out", {24'h0, out_port}, 32'h000000FF);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_rd($sformatf("p1_status%0d", k), 3'd5, (k % 2 == 0) ? 32'h0 : 32'h1);
            check($sformatf("p1_out%0d", k), {24'h0, out_port},
                  (k % 2 == 0) ? 32'h000000F0 : 32'h000000FF);
        end

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_out", {24'h0, out_port}, 32'h000000A5);
        check_rd("rst_data", 3'd0, 32'hA5);
        check_rd("rst_mask", 3'd1, 32'h0);
        check_rd("rst_period", 3'd2, 32'h0);
        check_rd("rst_status", 3'd5, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_rd("post_rst_status", 3'd5, 32'h1);
        check("post_rst_out", {24'h0, out_port}, 32'h000000A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
